// File: rtl/sr_shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sr_shift_ctrl
//  Description : Serializes a parallel word MSB-first into an external serial
//                shift register and deserializes what comes back out of it.
//                It then reports the returned word and whether it differs
//                from the word that was sent.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_shift_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             sr_in,
    input  logic             sr_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             err
);

    // Counter spans 0..WIDTH+DEPTH-1 over one transfer.
    localparam int CW = $clog2(WIDTH + DEPTH);

    localparam logic [CW-1:0] c_shift_last = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_cap_first  = CW'(DEPTH);
    localparam logic [CW-1:0] c_drain_last = CW'(WIDTH + DEPTH - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_shift = 2'd1;
    localparam logic [1:0] c_drain = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] tx_q;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] out_data_q;
    logic             err_q;
    logic [WIDTH-1:0] tx_shifted;
    logic             busy;

    assign busy = (state_q == c_shift) || (state_q == c_drain);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= c_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: transitions are keyed on the transfer counter.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_idle:  if (in_valid)                 state_d = c_shift;
            c_shift: if (cnt_q == c_shift_last)    state_d = c_drain;
            c_drain: if (cnt_q == c_drain_last)    state_d = c_done;
            c_done:  if (out_ready)                state_d = c_idle;
            default:                               state_d = c_idle;
        endcase
    end

    // Outputs decoded from state; sr_in picks transmit bit WIDTH-1-cnt.
    always_comb begin
        tx_shifted = tx_q << cnt_q;
        in_ready   = (state_q == c_idle);
        out_valid  = (state_q == c_done);
        sr_in      = (state_q == c_shift) ? tx_shifted[WIDTH-1] : 1'b0;
    end

    // Capture window: the bit sent at count c returns DEPTH cycles later, so
    // samples are taken for counts DEPTH..DEPTH+WIDTH-1 in SHIFT or DRAIN.
    always_comb begin
        cap_d = cap_q;
        if (busy && (cnt_q >= c_cap_first) && (cnt_q <= c_drain_last)) begin
            cap_d = {cap_q[WIDTH-2:0], sr_out};
        end
    end

    // Datapath: transmit latch, counter, capture and held result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            tx_q       <= '0;
            cap_q      <= '0;
            out_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if ((state_q == c_idle) && in_valid) begin
                tx_q  <= in_data;
                cnt_q <= '0;
            end else if (busy) begin
                cnt_q <= cnt_q + CW'(1);
            end
            cap_q <= cap_d;
            // Results are frozen on DONE entry so they persist outside DONE.
            if ((state_q == c_drain) && (cnt_q == c_drain_last)) begin
                out_data_q <= cap_d;
                err_q      <= (cap_d != tx_q);
            end
        end
    end

    assign out_data = out_data_q;
    assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr_shift_ctrl
//  Description : Self-checking bench for sr_shift_ctrl; three instances
//                (8/4, 2/4, 16/1) each looped through a modelled shift register.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_shift_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  inv, ordy, crpt;
    wire  [2:0]  ir, si, ov, er;
    logic [2:0]  so;
    logic [31:0] ind_a, ind_b, ind_c;
    wire  [7:0]  od_a;
    wire  [1:0]  od_b;
    wire  [15:0] od_c;
    logic [31:0] srq [3];

    int errors = 0;
    int checks = 0;

    sr_shift_ctrl #(.WIDTH(8), .DEPTH(4)) u_a (
        .clk(clk), .reset(reset), .in_valid(inv[0]), .in_ready(ir[0]),
        .in_data(ind_a[7:0]), .sr_in(si[0]), .sr_out(so[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .out_data(od_a), .err(er[0]));

    sr_shift_ctrl #(.WIDTH(2), .DEPTH(4)) u_b (
        .clk(clk), .reset(reset), .in_valid(inv[1]), .in_ready(ir[1]),
        .in_data(ind_b[1:0]), .sr_in(si[1]), .sr_out(so[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .out_data(od_b), .err(er[1]));

    sr_shift_ctrl #(.WIDTH(16), .DEPTH(1)) u_c (
        .clk(clk), .reset(reset), .in_valid(inv[2]), .in_ready(ir[2]),
        .in_data(ind_c[15:0]), .sr_in(si[2]), .sr_out(so[2]), .out_valid(ov[2]),
        .out_ready(ordy[2]), .out_data(od_c), .err(er[2]));

    // External serial shift registers; crpt inverts the bit entering the loop.
    always @(posedge clk) begin
        srq[0] <= {srq[0][30:0], si[0] ^ crpt[0]};
        srq[1] <= {srq[1][30:0], si[1] ^ crpt[1]};
        srq[2] <= {srq[2][30:0], si[2] ^ crpt[2]};
    end
    assign so = {srq[2][0], srq[1][3], srq[0][3]};

    function automatic logic [31:0] odata(input int s);
        case (s)
            0:       return {24'd0, od_a};
            1:       return {30'd0, od_b};
            default: return {16'd0, od_c};
        endcase
    endfunction

    function automatic int wid(input int s);
        return (s == 0) ? 8 : ((s == 1) ? 2 : 16);
    endfunction

    function automatic int dep(input int s);
        return (s == 0) ? 4 : ((s == 1) ? 4 : 1);
    endfunction

    task automatic set_data(input int s, input logic [31:0] v);
        case (s)
            0:       ind_a = v;
            1:       ind_b = v;
            default: ind_c = v;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One transfer: the expected stream is the word MSB-first, the expected
    // result is the word with the corrupted stream position flipped, and the
    // result must appear WIDTH+DEPTH edges after the acceptance edge.
    task automatic send(input int s, input logic [31:0] word, input int corrupt_k,
                        input int hold, input bit keep_valid);
        int          w, d, k;
        logic [31:0] mask, sent, exp_d;
        w     = wid(s);
        d     = dep(s);
        mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        sent  = word & mask;
        exp_d = sent;
        if (corrupt_k >= 0) exp_d = exp_d ^ (32'd1 << (w - 1 - corrupt_k));
        chk("in_ready_idle", {31'd0, ir[s]}, 32'd1);
        inv[s]  = 1'b1;
        set_data(s, sent);
        ordy[s] = (hold == 0);
        tick();
        k = 0;
        while ((ov[s] !== 1'b1) && (k < 200)) begin
            if (k == 0) chk("in_ready_busy", {31'd0, ir[s]}, 32'd0);
            if (k < w) chk("sr_in_bit", {31'd0, si[s]}, {31'd0, sent[w-1-k]});
            else       chk("sr_in_drain", {31'd0, si[s]}, 32'd0);
            crpt[s] = (k == corrupt_k);
            set_data(s, $urandom);
            tick();
            k++;
        end
        crpt[s] = 1'b0;
        chk("latency", k, w + d);
        chk("out_data", odata(s), exp_d);
        chk("err", {31'd0, er[s]}, {31'd0, exp_d != sent});
        chk("in_ready_done", {31'd0, ir[s]}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid", {31'd0, ov[s]}, 32'd1);
            chk("hold_data", odata(s), exp_d);
            chk("hold_err", {31'd0, er[s]}, {31'd0, exp_d != sent});
            chk("hold_in_ready", {31'd0, ir[s]}, 32'd0);
        end
        ordy[s] = 1'b1;
        tick();
        chk("valid_drop", {31'd0, ov[s]}, 32'd0);
        chk("in_ready_back", {31'd0, ir[s]}, 32'd1);
        chk("data_retained", odata(s), exp_d);
        if (!keep_valid) inv[s] = 1'b0;
    endtask

    initial begin
        inv   = '0;
        ordy  = '0;
        crpt  = '0;
        ind_a = '0;
        ind_b = '0;
        ind_c = '0;
        srq[0] = '0;
        srq[1] = '0;
        srq[2] = '0;
        @(negedge clk);
        tick();

        // Reset state
        chk("rst_in_ready", {31'd0, ir[0]}, 32'd1);
        chk("rst_out_valid", {31'd0, ov[0]}, 32'd0);
        chk("rst_out_data", odata(0), 32'd0);
        chk("rst_err", {31'd0, er[0]}, 32'd0);
        chk("rst_sr_in", {31'd0, si[0]}, 32'd0);
        reset = 1'b1;
        tick();
        chk("idle_no_valid", {31'd0, ov[0]}, 32'd0);

        // Basic transfer, back-pressure hold, and a corrupted loop
        send(0, 32'hA5, -1, 0, 1'b0);
        send(0, 32'h3C, -1, 5, 1'b0);
        send(0, 32'hFF, 3, 0, 1'b0);

        // Abort mid-transfer with an asynchronous reset
        inv[0]  = 1'b1;
        ind_a   = 32'h81;
        ordy[0] = 1'b1;
        tick();
        repeat (5) tick();
        reset = 1'b0;
        #1;
        chk("abort_in_ready", {31'd0, ir[0]}, 32'd1);
        chk("abort_out_valid", {31'd0, ov[0]}, 32'd0);
        chk("abort_out_data", odata(0), 32'd0);
        chk("abort_err", {31'd0, er[0]}, 32'd0);
        chk("abort_sr_in", {31'd0, si[0]}, 32'd0);
        inv[0] = 1'b0;
        @(negedge clk);
        tick();
        chk("abort_still_idle", {31'd0, ov[0]}, 32'd0);
        reset = 1'b1;

        // First acceptance right after release, then back-to-back with
        // in_valid held high and in_data churning throughout
        send(0, 32'h7E, -1, 0, 1'b1);
        send(0, $urandom, -1, 2, 1'b1);
        send(0, $urandom, -1, 0, 1'b0);

        // Parameter sweep
        for (int i = 0; i < 4; i++) send(1, $urandom, -1, 0, 1'b0);
        for (int i = 0; i < 3; i++) send(2, $urandom, -1, i, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
